// File: rtl/gonx_multicast_tx.sv
// GON X transmit-side multicaster: FIFO-buffered tagged values delivered to every PE
// whose scan-loaded ID equals the tag, with per-target ready gating and OR-gather-safe outputs.
module gonx_multicast_tx #(
  parameter int unsigned MASTER_NUMS = 14,
  parameter int unsigned ID_LEN      = 5,
  parameter int unsigned VALUE_LEN   = 32,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [ID_LEN-1:0]                     in_tag,
  input  logic [VALUE_LEN-1:0]                  in_value,
  output logic                                  in_ready,
  input  logic [MASTER_NUMS-1:0]                pe_ready,
  output logic [MASTER_NUMS-1:0][VALUE_LEN:0]   pe_enable_value,
  input  logic                                  set_id,
  input  logic [ID_LEN-1:0]                     id_scan_in,
  output logic [ID_LEN-1:0]                     id_scan_out,
  output logic                                  busy,
  output logic [7:0]                            drop_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  logic [ID_LEN-1:0]    fifo_tag   [FIFO_DEPTH];
  logic [VALUE_LEN-1:0] fifo_value [FIFO_DEPTH];
  logic [CNT_W-1:0]     wr_ptr, rd_ptr, wr_next, rd_next;
  logic [ID_LEN-1:0]    id [MASTER_NUMS];

  logic                   empty, full, push;
  logic [ID_LEN-1:0]      head_tag;
  logic [VALUE_LEN-1:0]   head_value;
  logic [MASTER_NUMS-1:0] match_c;
  logic                   pop_c, issue_c, drop_c;
  state_t                 state_c;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign in_ready   = !full;
  assign push       = in_valid && !full;
  assign head_tag   = fifo_tag[rd_ptr[PTR_W-1:0]];
  assign head_value = fifo_value[rd_ptr[PTR_W-1:0]];
  assign wr_next    = wr_ptr + CNT_W'(push);
  assign rd_next    = rd_ptr + CNT_W'(pop_c);
  assign id_scan_out = id[MASTER_NUMS-1];

  // Mode is decided from the current cycle so a scan edge never issues against stale IDs.
  always_comb begin
    state_c = IDLE;
    match_c = '0;
    pop_c   = 1'b0;
    issue_c = 1'b0;
    drop_c  = 1'b0;
    if (set_id)      state_c = HOLD;
    else if (!empty) state_c = ISSUE;
    for (int i = 0; i < MASTER_NUMS; i++)
      match_c[i] = (id[i] == head_tag) && (head_tag != {ID_LEN{1'b1}});
    case (state_c)
      ISSUE: begin
        if (&(pe_ready | ~match_c)) begin
          pop_c   = 1'b1;
          issue_c = |match_c;
          drop_c  = ~|match_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_tag[wr_ptr[PTR_W-1:0]]   <= in_tag;
      fifo_value[wr_ptr[PTR_W-1:0]] <= in_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      busy       <= 1'b0;
      drop_count <= '0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      busy   <= (wr_next != rd_next) || issue_c;
      if (drop_c && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  // ID scan chain: PE 0 takes the scan input, each later PE its predecessor's ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MASTER_NUMS; i++) id[i] <= {ID_LEN{1'b1}};
    end else if (set_id) begin
      id[0] <= id_scan_in;
      for (int i = 1; i < MASTER_NUMS; i++) id[i] <= id[i-1];
    end
  end

  // Untargeted PEs and idle cycles drive zeros to stay OR-gather compatible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_enable_value <= '0;
    end else begin
      for (int i = 0; i < MASTER_NUMS; i++)
        pe_enable_value[i] <= (issue_c && match_c[i]) ? {1'b1, head_value} : '0;
    end
  end

endmodule

// File: tb/tb_gonx_multicast_tx.sv
// Directed self-checking bench for gonx_multicast_tx: vector table for single transfers
// plus hand sequences for scan, backpressure, drop saturation, HOLD re-match and reset.
module tb_gonx_multicast_tx;

  localparam int unsigned MN = 14;
  localparam int unsigned IL = 5;
  localparam int unsigned VL = 32;

  logic                     clk, rst;
  logic                     in_valid;
  logic [IL-1:0]            in_tag;
  logic [VL-1:0]            in_value;
  logic                     in_ready;
  logic [MN-1:0]            pe_ready;
  logic [MN-1:0][VL:0]      pe_enable_value;
  logic                     set_id;
  logic [IL-1:0]            id_scan_in;
  logic [IL-1:0]            id_scan_out;
  logic                     busy;
  logic [7:0]               drop_count;

  gonx_multicast_tx #(.MASTER_NUMS(MN), .ID_LEN(IL), .VALUE_LEN(VL), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_tag(in_tag), .in_value(in_value),
    .in_ready(in_ready), .pe_ready(pe_ready), .pe_enable_value(pe_enable_value),
    .set_id(set_id), .id_scan_in(id_scan_in), .id_scan_out(id_scan_out),
    .busy(busy), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IL-1:0] tag;
    logic [VL-1:0] value;
    logic [MN-1:0] exp_en;
  } vec_t;

  vec_t vecs [6];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_drop = 0;
  int   pulses;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MN-1:0] en_vec();
    logic [MN-1:0] e;
    for (int i = 0; i < MN; i++) e[i] = pe_enable_value[i][VL];
    return e;
  endfunction

  task automatic check_outputs(input string name, input logic [MN-1:0] exp_en, input logic [VL-1:0] v);
    check({name, "_en"}, 64'(en_vec()), 64'(exp_en));
    for (int i = 0; i < MN; i++)
      check($sformatf("%s_pe%0d", name, i), 64'(pe_enable_value[i]),
            exp_en[i] ? 64'({1'b1, v}) : 64'd0);
  endtask

  task automatic load_mod4_ids();
    set_id = 1'b1;
    for (int j = MN - 1; j >= 0; j--) begin
      id_scan_in = IL'(j % 4);
      step();
    end
    set_id = 1'b0;
  endtask

  initial begin
    vecs[0] = '{tag: 5'd2,  value: 32'hDEADBEEF, exp_en: 14'h0444};
    vecs[1] = '{tag: 5'd0,  value: 32'h01234567, exp_en: 14'h1111};
    vecs[2] = '{tag: 5'd3,  value: 32'hCAFEF00D, exp_en: 14'h0888};
    vecs[3] = '{tag: 5'd1,  value: 32'h5A5A5A5A, exp_en: 14'h2222};
    vecs[4] = '{tag: 5'h1F, value: 32'hFFFFFFFF, exp_en: 14'h0000};
    vecs[5] = '{tag: 5'd7,  value: 32'h12345678, exp_en: 14'h0000};

    rst = 1'b1; in_valid = 1'b0; in_tag = '0; in_value = '0;
    pe_ready = '1; set_id = 1'b0; id_scan_in = '0;
    step();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_scan_out", 64'(id_scan_out), 64'h1F);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_en", 64'(en_vec()), 64'd0);
    rst = 1'b0;
    step();

    // Scan 0..13 in, then shift out with all-ones fill.
    set_id = 1'b1;
    for (int j = 0; j < MN; j++) begin
      id_scan_in = IL'(j);
      step();
    end
    for (int j = 0; j < MN; j++) begin
      check($sformatf("scan_out_%0d", j), 64'(id_scan_out), 64'(j));
      id_scan_in = 5'h1F;
      step();
    end
    set_id = 1'b0;
    check("scan_out_flushed", 64'(id_scan_out), 64'h1F);

    load_mod4_ids();

    // Table-driven single transfers, all PEs ready.
    for (int v = 0; v < 6; v++) begin
      in_valid = 1'b1; in_tag = vecs[v].tag; in_value = vecs[v].value;
      step();
      in_valid = 1'b0;
      check($sformatf("v%0d_latency1", v), 64'(en_vec()), 64'd0);
      step();
      check_outputs($sformatf("v%0d", v), vecs[v].exp_en, vecs[v].value);
      if (vecs[v].exp_en == '0) exp_drop++;
      check($sformatf("v%0d_drop", v), 64'(drop_count), 64'(exp_drop));
      step();
      check($sformatf("v%0d_after", v), 64'(en_vec()), 64'd0);
      check($sformatf("v%0d_idle", v), 64'(busy), 64'd0);
    end

    // Backpressure: tag 1 stalls on PE 5.
    pe_ready = '1; pe_ready[5] = 1'b0;
    in_valid = 1'b1; in_tag = 5'd1; in_value = 32'hA5A50001;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("stall_%0d", c), 64'(en_vec()), 64'd0);
    end
    pe_ready[5] = 1'b1;
    step();
    check_outputs("bp_release", 14'h2222, 32'hA5A50001);
    step();
    check("bp_after", 64'(en_vec()), 64'd0);

    // Five pushes against a stalled head: FIFO fills after the fourth.
    pe_ready[5] = 1'b0;
    for (int p = 0; p < 5; p++) begin
      in_valid = 1'b1; in_tag = 5'd1; in_value = 32'hB0000000 + p;
      step();
      check($sformatf("fill_ready_%0d", p), 64'(in_ready), (p >= 3) ? 64'd0 : 64'd1);
    end
    in_valid = 1'b0;
    pe_ready[5] = 1'b1;
    for (int p = 0; p < 4; p++) begin
      step();
      check_outputs($sformatf("drain_%0d", p), 14'h2222, 32'hB0000000 + p);
    end
    step();
    check("drain_done_en", 64'(en_vec()), 64'd0);
    check("drain_done_busy", 64'(busy), 64'd0);

    // Drops: two unmatched tags drain in two cycles.
    in_valid = 1'b1; in_tag = 5'h1F; in_value = 32'h1;
    step();
    in_tag = 5'd20;
    step();
    in_valid = 1'b0;
    exp_drop++;
    check("drop1_cnt", 64'(drop_count), 64'(exp_drop));
    check("drop1_busy", 64'(busy), 64'd1);
    check("drop1_en", 64'(en_vec()), 64'd0);
    step();
    exp_drop++;
    check("drop2_cnt", 64'(drop_count), 64'(exp_drop));
    check("drop2_busy", 64'(busy), 64'd0);
    check("drop2_en", 64'(en_vec()), 64'd0);

    // Saturation after 300 drops.
    in_valid = 1'b1; in_tag = 5'h1F;
    pulses = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (en_vec() != '0) pulses++;
    end
    in_valid = 1'b0;
    step();
    step();
    check("drop_sat", 64'(drop_count), 64'hFF);
    check("drop_no_en", 64'(pulses), 64'd0);
    check("drop_sat_busy", 64'(busy), 64'd0);

    // HOLD re-match: head tag 3 waits, one scan shift moves ID 3 to PEs 0,4,8,12.
    pe_ready = '1; pe_ready[3] = 1'b0;
    in_valid = 1'b1; in_tag = 5'd3; in_value = 32'hFEEDFACE;
    step();
    in_valid = 1'b0;
    step();
    check("hold_wait", 64'(en_vec()), 64'd0);
    pe_ready = '1;
    set_id = 1'b1; id_scan_in = 5'd3;
    step();
    set_id = 1'b0;
    check("hold_no_issue", 64'(en_vec()), 64'd0);
    check("hold_busy", 64'(busy), 64'd1);
    step();
    check_outputs("hold_rematch", 14'h1111, 32'hFEEDFACE);
    step();
    check("hold_after", 64'(en_vec()), 64'd0);

    // Async reset with three queued entries.
    pe_ready = '0;
    in_valid = 1'b1; in_tag = 5'd3;
    for (int p = 0; p < 3; p++) begin
      in_value = 32'hC0000000 + p;
      step();
    end
    in_valid = 1'b0;
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_en", 64'(en_vec()), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_scan_out", 64'(id_scan_out), 64'h1F);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_drop", 64'(drop_count), 64'd0);
    step();
    rst = 1'b0;
    pe_ready = '1;
    step();
    step();
    check("post_rst_en", 64'(en_vec()), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
